// File: rtl/step_sequencer.sv
// step_sequencer: run/pause/single-step clock-enable controller.
// Turns three raw board inputs (run button, step button, direction switch)
// into a one-cycle step_en strobe and a registered direction for the
// counting FSM, all in the clk domain. Each input goes through a 2-FF
// synchronizer and a debounce filter; button presses become one-cycle pulses.
// Optional feature macro: SEQ_STEP_COUNT_EN adds a 16-bit step_count output
// that counts step_en cycles (cleared by reset only).
module step_sequencer #(
    parameter int TICK_DIV   = 25000000,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_run,
    input  logic        btn_step,
    input  logic        mode_in,
    output logic        step_en,
    output logic        dir,
    output logic        running
`ifdef SEQ_STEP_COUNT_EN
    ,
    output logic [15:0] step_count
`endif
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    // Bit positions of the three inputs in the packed input-path vectors.
    localparam int RUN_I  = 0;
    localparam int STEP_I = 1;
    localparam int MODE_I = 2;

    typedef enum logic [1:0] {
        ST_PAUSE  = 2'd0,
        ST_RUN    = 2'd1,
        ST_SINGLE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input path: synchronizer -> debounce -> press pulse
    // ------------------------------------------------------------------
    logic [2:0]       raw_in;
    logic [2:0]       sync1_q, sync1_d;
    logic [2:0]       sync2_q, sync2_d;
    logic [2:0]       level_q, level_d;
    logic [2:0]       level_prev_q, level_prev_d;
    logic [2:0]       press_q, press_d;
    logic [DEB_W-1:0] deb_cnt_q [3];
    logic [DEB_W-1:0] deb_cnt_d [3];

    assign raw_in = {mode_in, btn_step, btn_run};

    // Debounce: the accepted level flips only after DEB_CYCLES consecutive
    // synced samples disagree with it; any agreeing sample restarts the count.
    always_comb begin
        sync1_d      = raw_in;
        sync2_d      = sync1_q;
        level_prev_d = level_q;
        press_d      = level_q & ~level_prev_q;
        for (int i = 0; i < 3; i++) begin
            deb_cnt_d[i] = deb_cnt_q[i];
            level_d[i]   = level_q[i];
            if (sync2_q[i] == level_q[i]) begin
                deb_cnt_d[i] = '0;
            end else if (deb_cnt_q[i] == DEB_LAST) begin
                level_d[i]   = sync2_q[i];
                deb_cnt_d[i] = '0;
            end else begin
                deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
            end
        end
    end

    // Input-path registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            level_q      <= '0;
            level_prev_q <= '0;
            press_q      <= '0;
            for (int i = 0; i < 3; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            level_q      <= level_d;
            level_prev_q <= level_prev_d;
            press_q      <= press_d;
            for (int i = 0; i < 3; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic              step_en_q, step_en_d;
    logic              running_q, running_d;
    logic              dir_q, dir_d;
    logic              run_press;
    logic              step_press;

    assign run_press  = press_q[RUN_I];
    assign step_press = press_q[STEP_I];

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_PAUSE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: run beats step in PAUSE; a step press landing right after
    // a step_en cycle is dropped so step_en can never fire back to back.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_PAUSE: begin
                if (run_press) begin
                    state_d = ST_RUN;
                end else if (step_press && !step_en_q) begin
                    state_d = ST_SINGLE;
                end
            end
            ST_RUN: begin
                if (run_press) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_SINGLE: state_d = ST_PAUSE;
            default:   state_d = ST_PAUSE;
        endcase
    end

    // Outputs: tick counter, step strobe, running flag and direction.
    // A wrap coinciding with a run press still issues its step_en.
    always_comb begin
        tick_d    = tick_q;
        step_en_d = 1'b0;
        case (state_q)
            ST_PAUSE: begin
                if (state_d == ST_RUN) begin
                    tick_d = '0;
                end
                if (state_d == ST_SINGLE) begin
                    step_en_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (tick_q == TICK_LAST) begin
                    step_en_d = 1'b1;
                end
                if (state_d == ST_RUN) begin
                    tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + TICK_W'(1);
                end
            end
            default: begin
                tick_d    = tick_q;
                step_en_d = 1'b0;
            end
        endcase
        running_d = (state_d == ST_RUN);
        dir_d     = step_en_d ? dir_q : level_q[MODE_I];
    end

    // Output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_q    <= '0;
            step_en_q <= 1'b0;
            running_q <= 1'b0;
            dir_q     <= 1'b0;
        end else begin
            tick_q    <= tick_d;
            step_en_q <= step_en_d;
            running_q <= running_d;
            dir_q     <= dir_d;
        end
    end

    assign step_en = step_en_q;
    assign running = running_q;
    assign dir     = dir_q;

`ifdef SEQ_STEP_COUNT_EN
    logic [15:0] step_count_q, step_count_d;

    // Step counter advances together with each step_en cycle, wrapping at 16 bits.
    always_comb begin
        step_count_d = step_count_q + {15'd0, step_en_d};
    end

    // Step counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step_count_q <= '0;
        end else begin
            step_count_q <= step_count_d;
        end
    end

    assign step_count = step_count_q;
`endif

endmodule
